// File: rtl/programmable_clock_divider.sv
// programmable_clock_divider
// Multi-channel runtime-programmable clock divider and tick generator.
// Each channel runs its own counter against its own divisor. Each channel
// produces a near-50% duty divided clock and a one-cycle tick in the last
// cycle of every period.
//
// Configuration handshake (valid/ready): a request transfers on a rising
// edge where cfg_valid && cfg_ready. cfg_valid and the cfg_* payload must be
// held stable until that edge. cfg_ready depends only on registered state:
// it is low only while a deferred request waits in the single pending slot.
module programmable_clock_divider #(
  parameter int CHANNELS        = 4,
  parameter int CHANNEL_BITS    = 2,
  parameter int COUNTER_SIZE    = 16,
  parameter int DEFAULT_DIVISOR = 50
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [CHANNELS-1:0]     enable,
  input  logic                    sync_restart,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CHANNEL_BITS-1:0] cfg_channel,
  input  logic [COUNTER_SIZE-1:0] cfg_divisor,
  input  logic                    cfg_immediate,
  output logic [CHANNELS-1:0]     tick,
  output logic [CHANNELS-1:0]     divided_clock
);

  localparam logic [COUNTER_SIZE-1:0] ONE     = COUNTER_SIZE'(1);
  localparam logic [COUNTER_SIZE-1:0] TWO     = COUNTER_SIZE'(2);
  localparam logic [COUNTER_SIZE-1:0] DEF_DIV = COUNTER_SIZE'(DEFAULT_DIVISOR);

  // Per-channel state
  logic [COUNTER_SIZE-1:0] r_div [CHANNELS];
  logic [COUNTER_SIZE-1:0] r_cnt [CHANNELS];
  logic [CHANNELS-1:0]     r_tick;
  logic [CHANNELS-1:0]     r_dclk;

  // Single pending slot for deferred configuration
  logic                    r_pend_valid;
  logic [CHANNEL_BITS-1:0] r_pend_ch;
  logic [COUNTER_SIZE-1:0] r_pend_div;

  // Combinational next-state
  logic                    w_accept;
  logic                    w_ch_ok;
  logic                    w_imm_accept;
  logic                    w_def_accept;
  logic [COUNTER_SIZE-1:0] w_cfg_div;
  logic [CHANNELS-1:0]     w_imm_hit;
  logic [CHANNELS-1:0]     w_pend_hit;
  logic [CHANNELS-1:0]     w_pend_take;
  logic [CHANNELS-1:0]     w_wrap;
  logic [COUNTER_SIZE-1:0] w_div_nxt [CHANNELS];
  logic [COUNTER_SIZE-1:0] w_cnt_nxt [CHANNELS];
  logic [COUNTER_SIZE-1:0] w_half    [CHANNELS];
  logic [CHANNELS-1:0]     w_tick_nxt;
  logic [CHANNELS-1:0]     w_dclk_nxt;

  assign cfg_ready     = ~r_pend_valid;
  assign tick          = r_tick;
  assign divided_clock = r_dclk;

  // Decode the configuration request; out-of-range channels are accepted and dropped
  always_comb begin
    w_accept     = cfg_valid && cfg_ready;
    w_ch_ok      = int'(cfg_channel) < CHANNELS;
    w_imm_accept = w_accept && w_ch_ok && cfg_immediate;
    w_def_accept = w_accept && w_ch_ok && !cfg_immediate;
    w_cfg_div    = (cfg_divisor < TWO) ? TWO : cfg_divisor;
  end

  // Per-channel next counter/divisor with priority: immediate, sync, wrap, count, park
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_imm_hit[i]   = w_imm_accept && (int'(cfg_channel) == i);
      w_pend_hit[i]  = r_pend_valid && (int'(r_pend_ch) == i);
      w_wrap[i]      = (r_cnt[i] == (r_div[i] - ONE));
      w_pend_take[i] = 1'b0;
      w_div_nxt[i]   = r_div[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (w_imm_hit[i]) begin
        // An immediate write also cancels a deferred one aimed at this channel
        w_div_nxt[i]   = w_cfg_div;
        w_cnt_nxt[i]   = enable[i] ? '0 : (w_cfg_div - ONE);
        w_pend_take[i] = w_pend_hit[i];
      end else if (enable[i] && (sync_restart || w_wrap[i])) begin
        w_cnt_nxt[i] = '0;
        if (w_pend_hit[i]) begin
          w_div_nxt[i]   = r_pend_div;
          w_pend_take[i] = 1'b1;
        end
      end else if (enable[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + ONE;
      end else if (w_pend_hit[i]) begin
        // Disabled target: take the new divisor now and park at its last count
        w_div_nxt[i]   = r_pend_div;
        w_cnt_nxt[i]   = r_pend_div - ONE;
        w_pend_take[i] = 1'b1;
      end else begin
        w_cnt_nxt[i] = r_div[i] - ONE;
      end
      w_half[i]     = w_div_nxt[i] - (w_div_nxt[i] >> 1);
      w_tick_nxt[i] = enable[i] && (w_cnt_nxt[i] == (w_div_nxt[i] - ONE));
      w_dclk_nxt[i] = enable[i] && (w_cnt_nxt[i] < w_half[i]);
    end
  end

  // Channel counters, divisors and registered output decodes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_div[i] <= DEF_DIV;
        r_cnt[i] <= DEF_DIV - ONE;
      end
      r_tick <= '0;
      r_dclk <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_div[i] <= w_div_nxt[i];
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_tick <= w_tick_nxt;
      r_dclk <= w_dclk_nxt;
    end
  end

  // Pending slot: filled by a deferred accept, emptied when its target takes it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_ch    <= '0;
      r_pend_div   <= DEF_DIV;
    end else begin
      if (|w_pend_take) begin
        r_pend_valid <= 1'b0;
      end
      if (w_def_accept) begin
        r_pend_valid <= 1'b1;
        r_pend_ch    <= cfg_channel;
        r_pend_div   <= w_cfg_div;
      end
    end
  end

endmodule

// File: doc/programmable_clock_divider.md
# programmable_clock_divider

Multi-channel, runtime-programmable clock divider and tick generator. It generalises the single fixed-ratio divider: each of `CHANNELS` independent counters has its own divisor loaded through a valid/ready configuration port, its own enable, a near-50% duty divided output and a single-cycle tick. All channels can be phase-aligned on demand. It sits beside the sensor interface logic and supplies sampling strobes and slow bus clocks from the single system clock.

## Interface
- `CHANNELS`, 4: number of independent divider channels.
- `CHANNEL_BITS`, 2: width of `cfg_channel`; 2^CHANNEL_BITS >= CHANNELS.
- `COUNTER_SIZE`, 16: width of each counter and each divisor.
- `DEFAULT_DIVISOR`, 50: divisor of every channel after reset (50 MHz -> 1 MHz); must be >= 2.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  CHANNELS  per-channel run enable.
- `sync_restart`  in  1  one-cycle pulse; restarts all enabled channels at count 0.
- `cfg_valid`  in  1  configuration request valid.
- `cfg_ready`  out  1  configuration slot free.
- `cfg_channel`  in  CHANNEL_BITS  target channel.
- `cfg_divisor`  in  COUNTER_SIZE  new divisor D.
- `cfg_immediate`  in  1  1 = apply now, 0 = apply at the next period boundary.
- `tick`  out  CHANNELS  one-cycle pulse in the last cycle of each period.
- `divided_clock`  out  CHANNELS  divided square wave.

## Operation
- Per channel state: `div[i]` (D), `cnt[i]`. `tick` and `divided_clock` are registered decodes of the post-edge `cnt`: `tick[i] = enable && cnt==D-1`, `divided_clock[i] = enable && cnt < ceil(D/2)`.
- Enabled: `cnt` counts 0..D-1 and wraps to 0. Period is D cycles. High time is ceil(D/2) and low time is floor(D/2), so odd D gives a longer high phase.
- Disabled: `cnt` parks at D-1, and `tick`=0, `divided_clock`=0. The first enabled edge loads `cnt`=0 (`divided_clock` rises) and the first tick follows D-1 cycles later.
- Divisor clamp: a `cfg_divisor` below 2 is stored as 2. Arithmetic is unsigned, COUNTER_SIZE bits, and there is no overflow because `cnt` never exceeds D-1.
- Config handshake: the request is accepted on an edge with `cfg_valid && cfg_ready`.
  - Immediate: on the accepting edge `div`<=new D and `cnt`<=0 (enabled) or new D-1 (disabled). Nothing is held pending, so `cfg_ready` stays 1.
  - Deferred: the request is stored in the single pending slot and `cfg_ready` drops on the next cycle. It is applied on the edge where the target wraps (`cnt`==D-1 and enabled). That edge loads `cnt`=0 and `div`=new D. If the target is disabled, it is applied on the next edge with `cnt`=new D-1. `cfg_ready` returns to 1 on the cycle after application.
  - `cfg_channel` >= CHANNELS: the request is accepted and discarded, with no state change.
- `sync_restart`: on that edge every enabled channel loads `cnt`=0. Any pending deferred config for an enabled target is applied on the same edge. This has priority over normal wrap. Disabled channels are unaffected.
- Priority per channel, highest first: reset, immediate config, sync_restart, deferred application at wrap, count.

## Timing
- Reset (asynchronous, while `reset_n`=0):
  - every `div`=DEFAULT_DIVISOR and `cnt`=DEFAULT_DIVISOR-1;
  - `tick`=0, `divided_clock`=0;
  - pending slot cleared, `cfg_ready`=1.
- Reset mid-period or mid-pending discards all state, and the sequence restarts as after power-up.
- Latency: outputs reflect the counter one edge after it changes, with no combinational path from inputs to outputs except `cfg_ready`, which is a function of registered state only.
- Back-to-back immediate configs are accepted every cycle. Only the last config to a given channel survives.
- A deferred request and an immediate request to the same channel in the same pending window: the immediate request also clears the pending slot if it targets the same channel.

## Test plan
- Reset release, `enable`=4'b0001, D=50 -> `tick[0]` every 50 cycles, first one 49 cycles after the first enabled edge; `divided_clock[0]` 25 high / 25 low; other outputs stay 0.
- Immediate config of ch1 to D=5 -> `cnt` restarts next edge; `divided_clock[1]` 3 high / 2 low; `tick[1]` every 5 cycles.
- Deferred config of ch0 to D=4 issued at `cnt`=10 (D=50) -> `cfg_ready`=0 until the wrap; 39 more cycles at D=50, then period 4; `cfg_ready`=1 one cycle after the wrap.
- Divisor 0 and 1 -> stored as 2; `divided_clock` toggles every cycle; `tick` every 2 cycles.
- Channels at D=3, 7 and 10 with `sync_restart` pulsed -> all `divided_clock` rise on the same cycle; disabled ch3 stays 0.
- `reset_n` asserted mid-pending -> outputs 0 immediately (asynchronous); after release `cfg_ready`=1 and all divisors are 50.
